pixels_averaging: RTL and testbench



---
 rtl/pooling_pkg.sv | 19 +
 rtl/pixels_averaging.sv | 115 +++++++++++
 tb/tb_pixels_averaging.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pooling_pkg.sv
// Shared types and widths for the average-pooling layer of the digit-recognition datapath.
// Holds pixel/sum widths, the signed pixel type and the averager state encoding.
// Imported by pixels_averaging; no logic lives here.
package pooling_pkg;

    localparam int PIXEL_WIDTH = 8;
    // Four signed pixels summed need two extra bits to never overflow.
    localparam int SUM_WIDTH   = PIXEL_WIDTH + 2;

    typedef logic signed [PIXEL_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } avg_state_t;

endpackage

// File: rtl/pixels_averaging.sv
// Four-input signed pixel averager: captures a 2x2 window, sums it, divides by four.
// Latency: avg valid and done=1 two edges after the edge that samples enable; one result per 4 cycles.
// No backpressure: enable is sampled only in IDLE; a started operation always completes unless reset.
//
// Ports: clk, reset (async, active-high), enable, pix_a..pix_d (signed WIDTH) in;
//        avg (signed WIDTH, registered, held) and done (one-cycle pulse) out.
// Build option: PIXELS_AVERAGING_ROUND_EN selects round-to-nearest (ties toward +inf)
//        instead of the default floor (arithmetic shift).
module pixels_averaging
    import pooling_pkg::*;
#(
    parameter int WIDTH = PIXEL_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] pix_a,
    input  logic signed [WIDTH-1:0] pix_b,
    input  logic signed [WIDTH-1:0] pix_c,
    input  logic signed [WIDTH-1:0] pix_d,
    output logic signed [WIDTH-1:0] avg,
    output logic                    done
);

    localparam int SW = WIDTH + 2;

    avg_state_t              state_q, state_d;
    logic signed [WIDTH-1:0] pix_a_q, pix_a_d;
    logic signed [WIDTH-1:0] pix_b_q, pix_b_d;
    logic signed [WIDTH-1:0] pix_c_q, pix_c_d;
    logic signed [WIDTH-1:0] pix_d_q, pix_d_d;
    logic signed [SW-1:0]    sum_q, sum_d;
    logic signed [WIDTH-1:0] avg_q, avg_d;
    logic                    done_q, done_d;

    logic signed [SW-1:0]    sum_adj;
    logic signed [SW-1:0]    quot;

    function automatic logic signed [SW-1:0] sext(input logic signed [WIDTH-1:0] p);
        return {{2{p[WIDTH-1]}}, p};
    endfunction

    // The +2 cannot overflow: the largest sum is 4*(2^(W-1)-1), well below 2^(W+1)-1.
    always_comb begin
`ifdef PIXELS_AVERAGING_ROUND_EN
        sum_adj = sum_q + SW'(2);
`else
        sum_adj = sum_q;
`endif
        quot = sum_adj >>> 2;
    end

    always_comb begin
        state_d = state_q;
        pix_a_d = pix_a_q;
        pix_b_d = pix_b_q;
        pix_c_d = pix_c_q;
        pix_d_d = pix_d_q;
        sum_d   = sum_q;
        avg_d   = avg_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    pix_a_d = pix_a;
                    pix_b_d = pix_b;
                    pix_c_d = pix_c;
                    pix_d_d = pix_d;
                    state_d = SUM;
                end
            end
            SUM: begin
                sum_d   = sext(pix_a_q) + sext(pix_b_q) + sext(pix_c_q) + sext(pix_d_q);
                state_d = DIV;
            end
            DIV: begin
                // Quotient always fits the pixel range, so truncation is exact.
                avg_d   = quot[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                // enable deliberately ignored here to give the controller a cycle to advance.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pix_a_q <= '0;
            pix_b_q <= '0;
            pix_c_q <= '0;
            pix_d_q <= '0;
            sum_q   <= '0;
            avg_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_a_q <= pix_a_d;
            pix_b_q <= pix_b_d;
            pix_c_q <= pix_c_d;
            pix_d_q <= pix_d_d;
            sum_q   <= sum_d;
            avg_q   <= avg_d;
            done_q  <= done_d;
        end
    end

    assign avg  = avg_q;
    assign done = done_q;

endmodule

// File: tb/tb_pixels_averaging.sv
// Directed self-checking bench for pixels_averaging.
// Expected values are hand-computed; the rounding build is selected by PIXELS_AVERAGING_ROUND_EN.
// Outputs are sampled on the falling edge; inputs are driven away from the rising edge.
module tb_pixels_averaging;

    logic              clk;
    logic              reset;
    logic              enable;
    logic signed [7:0] pix_a, pix_b, pix_c, pix_d;
    logic signed [7:0] avg;
    logic              done;

    int n_checks;
    int n_fail;

    pixels_averaging #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .pix_a  (pix_a),
        .pix_b  (pix_b),
        .pix_c  (pix_c),
        .pix_d  (pix_d),
        .avg    (avg),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one operation starting from IDLE. After the capture edge the inputs are
    // scrambled and enable dropped, so the result must come from the captured window.
    // done_pat bit i = done at the falling edge after edge E0+i.
    task automatic do_op(input int a, input int b, input int c, input int d,
                         output logic [3:0] done_pat, output logic signed [7:0] avg_at_done);
        @(negedge clk);
        pix_a = 8'(a); pix_b = 8'(b); pix_c = 8'(c); pix_d = 8'(d);
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        pix_a = 8'sd99; pix_b = -8'sd77; pix_c = 8'sd55; pix_d = -8'sd33;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            done_pat[i] = done;
            if (i == 2) avg_at_done = avg;
        end
    endtask

    task automatic test_reset();
        logic saw_done;
        logic [3:0] pat;
        logic signed [7:0] a2;
        reset = 1'b1; enable = 1'b1;
        pix_a = 8'sd4; pix_b = 8'sd8; pix_c = 8'sd12; pix_d = 8'sd16;
        #1;
        n_checks++;
        if (avg !== 8'sd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_immediate: avg=%0d done=%b, required avg=0 done=0", avg, done);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done || avg !== 8'sd0) begin
            n_fail++;
            $display("FAIL reset_hold: saw_done=%b avg=%0d, required no pulse and avg=0", saw_done, avg);
        end
        // Release with enable still high: first edge captures 4,8,12,16 -> 10.
        reset = 1'b0;
        @(posedge clk);
        #1;
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[i] = done;
            if (i == 2) a2 = avg;
        end
        n_checks++;
        if (pat !== 4'b0100 || a2 !== 8'sd10) begin
            n_fail++;
            $display("FAIL reset_release_op: done_pat=%b avg=%0d, required 0100 and 10", pat, a2);
        end
    endtask

    task automatic test_basic();
        logic [3:0] pat;
        logic signed [7:0] a2;
        do_op(10, 20, 30, 40, pat, a2);
        n_checks++;
        if (pat !== 4'b0100) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done_pat=%b, required 0100", pat);
        end
        n_checks++;
        if (a2 !== 8'sd25) begin
            n_fail++;
            $display("FAIL basic_avg: avg=%0d, required 25", a2);
        end
    endtask

    task automatic test_extremes();
        logic [3:0] pat;
        logic signed [7:0] a2;
        do_op(127, 127, 127, 127, pat, a2);
        n_checks++;
        if (pat !== 4'b0100 || a2 !== 8'sd127) begin
            n_fail++;
            $display("FAIL max_avg: done_pat=%b avg=%0d, required 0100 and 127", pat, a2);
        end
        do_op(-128, -128, -128, -128, pat, a2);
        n_checks++;
        if (pat !== 4'b0100 || a2 !== -8'sd128) begin
            n_fail++;
            $display("FAIL min_avg: done_pat=%b avg=%0d, required 0100 and -128", pat, a2);
        end
    endtask

    task automatic test_rounding();
        logic [3:0] pat;
        logic signed [7:0] a2;
        logic signed [7:0] exp_neg;
`ifdef PIXELS_AVERAGING_ROUND_EN
        exp_neg = -8'sd1;
`else
        exp_neg = -8'sd2;
`endif
        do_op(1, 1, 1, 2, pat, a2);
        n_checks++;
        if (a2 !== 8'sd1) begin
            n_fail++;
            $display("FAIL round_pos: avg=%0d, required 1", a2);
        end
        do_op(-1, -1, -1, -2, pat, a2);
        n_checks++;
        if (a2 !== exp_neg) begin
            n_fail++;
            $display("FAIL round_neg: avg=%0d, required %0d", a2, exp_neg);
        end
        // -6/4 = -1.5: floor gives -2, ties toward +inf gives -1.
        do_op(-1, -1, -2, -2, pat, a2);
        n_checks++;
        if (a2 !== exp_neg) begin
            n_fail++;
            $display("FAIL round_tie_neg: avg=%0d, required %0d", a2, exp_neg);
        end
    endtask

    task automatic test_hold();
        logic signed [7:0] a0;
        logic [3:0] pat;
        logic bad;
        do_op(-40, -40, -40, -40, pat, a0);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pix_a = 8'(i * 7); pix_b = 8'(i); pix_c = 8'sd3; pix_d = -8'sd9;
            if (avg !== -8'sd40 || done !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL avg_hold: avg=%0d done=%b, required avg held at -40 with no pulse", avg, done);
        end
    endtask

    // enable held high, inputs changed every cycle. Cycle k inputs: 8k,8k,8k,8k+4
    // so average is 8k+1 in both builds. Captures at k=0,4,8 -> done seen at k=3,7,11.
    task automatic test_back_to_back();
        int pulses;
        logic exp_done;
        int k_cap;
        pulses = 0;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            exp_done = (k >= 3) && ((k % 4) == 3);
            n_checks++;
            if (done !== exp_done) begin
                n_fail++;
                $display("FAIL b2b_done_k%0d: done=%b, required %b", k, done, exp_done);
            end
            if (exp_done) begin
                pulses++;
                k_cap = k - 3;
                n_checks++;
                if (avg !== 8'(8 * k_cap + 1)) begin
                    n_fail++;
                    $display("FAIL b2b_avg_k%0d: avg=%0d, required %0d", k, avg, 8 * k_cap + 1);
                end
            end
            if (k < 12) begin
                enable = 1'b1;
                pix_a = 8'(8 * k); pix_b = 8'(8 * k); pix_c = 8'(8 * k); pix_d = 8'(8 * k + 4);
            end else begin
                enable = 1'b0;
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL b2b_pulse_count: pulses=%0d, required 3", pulses);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic bad;
        logic [3:0] pat;
        logic signed [7:0] a2;
        do_op(10, 20, 30, 40, pat, a2);
        @(negedge clk);
        pix_a = 8'sd40; pix_b = 8'sd40; pix_c = 8'sd40; pix_d = 8'sd40;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (avg !== 8'sd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_immediate: avg=%0d done=%b, required 0 and 0", avg, done);
        end
        @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || avg !== 8'sd0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL abort_no_done: avg=%0d done=%b, required avg 0 and no pulse", avg, done);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset  = 1'b1;
        enable = 1'b0;
        pix_a = '0; pix_b = '0; pix_c = '0; pix_d = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_rounding();
        test_hold();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case a task ever stalls on the clock.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion before 100000");
        $fatal(1, "timeout");
    end

endmodule
